// File: rtl/axis_vgen_pkg.sv
// Shared encodings for the AXI4-Stream video pattern generator: FSM states,
// pattern selectors and the fixed colour constants used by the pixel function.
package axis_vgen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  localparam logic [23:0] GRID_CROSS = 24'hFF0000;
  localparam logic [23:0] GRID_LINE  = 24'hFFFFFF;
  localparam logic [23:0] GRID_BG    = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/axis_vgen_pattern.sv
// Combinational pixel function: maps the coordinates of the beat being loaded
// (plus bar index, latched pattern/colour and frame number) to an RGB888 value.
module axis_vgen_pattern
  import axis_vgen_pkg::*;
#(
  parameter int WIDTH        = 1920,
  parameter int HEIGHT       = 1080,
  parameter int COORD_WIDTH  = 16,
  parameter int GRID_SPACING = 64
) (
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic [2:0]             bar_idx,
  input  logic [1:0]             pattern,
  input  logic [23:0]            color,
  input  logic [7:0]             frame,
  output logic [23:0]            pixel
);

  localparam logic [COORD_WIDTH-1:0] X_MID     = COORD_WIDTH'(WIDTH / 2);
  localparam logic [COORD_WIDTH-1:0] Y_MID     = COORD_WIDTH'(HEIGHT / 2);
  localparam logic [COORD_WIDTH-1:0] X_LAST    = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST    = COORD_WIDTH'(HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] GRID_MASK = COORD_WIDTH'(GRID_SPACING - 1);

  logic on_cross;
  logic on_grid;

  always_comb begin
    on_cross = (x == X_MID) || (y == Y_MID);
    // Pitch is a power of two, so the modulo reduces to masking the low bits.
    on_grid  = ((x & GRID_MASK) == '0) || ((y & GRID_MASK) == '0) ||
               (x == X_LAST) || (y == Y_LAST);
    pixel    = '0;
    case (pattern)
      PAT_SOLID: pixel = color;
      PAT_BARS:  pixel = bar_color(bar_idx);
      PAT_GRID:  pixel = on_cross ? GRID_CROSS : (on_grid ? GRID_LINE : GRID_BG);
      PAT_RAMP:  pixel = {x[7:0], y[7:0], frame};
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream raster test-pattern source (solid, bars, grid, ramp).
// Define AXIS_VGEN_HBLANK_EN to insert an H_BLANK-cycle idle gap after every line.
module axis_video_pattern_gen
  import axis_vgen_pkg::*;
#(
  parameter int WIDTH        = 1920,
  parameter int HEIGHT       = 1080,
  parameter int DATA_WIDTH   = 24,
  parameter int COORD_WIDTH  = 16,
  parameter int GRID_SPACING = 64,
  parameter int H_BLANK      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] solid_color,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  if (DATA_WIDTH != 24) begin : g_bad_data_width
    $error("axis_video_pattern_gen supports only DATA_WIDTH=24");
  end
  if (H_BLANK < 0) begin : g_bad_hblank
    $error("axis_video_pattern_gen requires H_BLANK >= 0");
  end

  localparam logic [COORD_WIDTH-1:0] X_LAST   = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST   = COORD_WIDTH'(HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] BAR_LAST = COORD_WIDTH'(WIDTH / 8 - 1);

  // Valid/ready: a beat transfers on a rising edge where tvalid and tready are
  // both high; once tvalid is raised, tdata/tlast/tuser hold until that edge.
  logic [1:0]             state;
  logic [COORD_WIDTH-1:0] x_q, y_q, bar_cnt_q;
  logic [2:0]             bar_idx_q;
  logic [1:0]             pat_q;
  logic [DATA_WIDTH-1:0]  color_q;
  logic [15:0]            frames_q;
  logic                   done_pend;
`ifdef AXIS_VGEN_HBLANK_EN
  localparam logic [15:0] HB_LOAD = 16'(H_BLANK - 1);
  logic [15:0]            hb_cnt;
`endif

  logic                   accept, line_end, frame_end, start;
  logic                   last_accept, new_frame, advance, load;
  logic [COORD_WIDTH-1:0] x_nxt, y_nxt, bar_cnt_nxt;
  logic [2:0]             bar_idx_nxt;
  logic [1:0]             pat_nxt;
  logic [DATA_WIDTH-1:0]  color_nxt;
  logic [15:0]            frame_nxt;
  logic [DATA_WIDTH-1:0]  pixel;

  assign busy        = (state != ST_IDLE);
  assign accept      = m_axis_tvalid && m_axis_tready;
  assign line_end    = (x_q == X_LAST);
  assign frame_end   = line_end && (y_q == Y_LAST);
  assign start       = (state == ST_IDLE) && enable;
  assign last_accept = (state == ST_ACTIVE) && accept && frame_end;
  assign new_frame   = start || (last_accept && enable);
  assign advance     = (state == ST_ACTIVE) && accept && !frame_end;
  assign load        = new_frame || advance;

  // Frame settings are re-latched only at a frame boundary.
  assign pat_nxt   = new_frame ? pattern_sel : pat_q;
  assign color_nxt = new_frame ? solid_color : color_q;
  assign frame_nxt = last_accept ? frames_q + 16'd1 : frames_q;

  always_comb begin
    x_nxt       = x_q;
    y_nxt       = y_q;
    bar_cnt_nxt = bar_cnt_q;
    bar_idx_nxt = bar_idx_q;
    if (new_frame) begin
      x_nxt       = '0;
      y_nxt       = '0;
      bar_cnt_nxt = '0;
      bar_idx_nxt = '0;
    end else if (line_end) begin
      x_nxt       = '0;
      y_nxt       = y_q + 1'b1;
      bar_cnt_nxt = '0;
      bar_idx_nxt = '0;
    end else begin
      x_nxt = x_q + 1'b1;
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_nxt = '0;
        bar_idx_nxt = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_nxt = bar_cnt_q + 1'b1;
      end
    end
  end

  axis_vgen_pattern #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .COORD_WIDTH (COORD_WIDTH),
    .GRID_SPACING(GRID_SPACING)
  ) u_pattern (
    .x      (x_nxt),
    .y      (y_nxt),
    .bar_idx(bar_idx_nxt),
    .pattern(pat_nxt),
    .color  (color_nxt),
    .frame  (frame_nxt[7:0]),
    .pixel  (pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      pat_q         <= '0;
      color_q       <= '0;
      frames_q      <= '0;
      done_pend     <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
`ifdef AXIS_VGEN_HBLANK_EN
      hb_cnt        <= '0;
`endif
    end else begin
      // frames_q feeds the ramp immediately; the visible count lags one edge.
      done_pend  <= last_accept;
      frame_done <= done_pend;
      frames_q   <= frame_nxt;
      if (done_pend) frame_cnt <= frame_cnt + 16'd1;

      if (load) begin
        x_q          <= x_nxt;
        y_q          <= y_nxt;
        bar_cnt_q    <= bar_cnt_nxt;
        bar_idx_q    <= bar_idx_nxt;
        pat_q        <= pat_nxt;
        color_q      <= color_nxt;
        m_axis_tdata <= pixel;
        m_axis_tlast <= (x_nxt == X_LAST);
        m_axis_tuser <= (x_nxt == '0) && (y_nxt == '0);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_ACTIVE;
            m_axis_tvalid <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (accept) begin
            if (frame_end && !enable) begin
              state         <= ST_IDLE;
              m_axis_tvalid <= 1'b0;
            end
`ifdef AXIS_VGEN_HBLANK_EN
            else if (line_end && (H_BLANK > 0)) begin
              // Next beat is already loaded; only tvalid is held off.
              state         <= ST_HBLANK;
              m_axis_tvalid <= 1'b0;
              hb_cnt        <= HB_LOAD;
            end
`endif
          end
        end
`ifdef AXIS_VGEN_HBLANK_EN
        ST_HBLANK: begin
          if (hb_cnt == '0) begin
            state         <= ST_ACTIVE;
            m_axis_tvalid <= 1'b1;
          end else begin
            hb_cnt <= hb_cnt - 16'd1;
          end
        end
`endif
        default: begin
          state         <= ST_IDLE;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule
